// File: rtl/normalize_round_pack_float64_if.sv
// ============================================================================
// Module      : normalize_round_pack_float64_if
// Description : Block-level handshake and operand/result bundle for the
//               float64 normalize/round/pack stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface normalize_round_pack_float64_if;
    logic        ap_start;
    logic        ap_done;
    logic        ap_idle;
    logic        ap_ready;
    logic        zSign;
    logic [13:0] zExp;
    logic [63:0] zSig;
    logic [1:0]  round_mode;
    logic [63:0] ap_return;
    logic [2:0]  flags;

    modport master (
        output ap_start, zSign, zExp, zSig, round_mode,
        input  ap_done, ap_idle, ap_ready, ap_return, flags
    );

    modport slave (
        input  ap_start, zSign, zExp, zSig, round_mode,
        output ap_done, ap_idle, ap_ready, ap_return, flags
    );
endinterface

`default_nettype wire

// File: rtl/normalize_round_pack_float64.sv
// ============================================================================
// Module      : normalize_round_pack_float64
// Description : Normalizes, rounds (IEEE-754 / SoftFloat) and packs a raw
//               sign/exponent/significand into a float64 with flags.
//               Define NRP_ROUND_MODES_EN to honour all four rounding modes;
//               otherwise rounding is fixed to nearest-even.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module normalize_round_pack_float64 (
    input  wire logic                     ap_clk,
    input  wire logic                     ap_rst,
    normalize_round_pack_float64_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_NORM = 2'd1;
    localparam logic [1:0] S_RND  = 2'd2;
    localparam logic [1:0] S_PACK = 2'd3;

    localparam logic [13:0] c_EXP_OVF   = 14'h07FD;
    localparam logic [63:0] c_FRAC_MAX  = 64'h000F_FFFF_FFFF_FFFF;

    logic [1:0]  r_state;
    logic        r_sign;
    logic [13:0] r_zexp;
    logic [63:0] r_zsig;
    logic [13:0] r_exp;
    logic [63:0] r_sig;
    logic        r_zero;
    logic [2:0]  r_nflags;
    logic [63:0] r_return;
    logic [2:0]  r_flags;
    logic        r_done;
`ifdef NRP_ROUND_MODES_EN
    logic [1:0]  r_mode;
`endif

    // Leading-zero count; the highest set bit is the last one to win the loop
    logic [6:0] w_clz;
    logic [5:0] w_sc;
    always_comb begin
        w_clz = 7'd64;
        for (int i = 0; i < 64; i++) begin
            if (r_zsig[i]) w_clz = 7'(63 - i);
        end
        w_sc = (w_clz == 7'd64) ? 6'd63 : (w_clz[5:0] - 6'd1);
    end

    logic [63:0] w_inc;
    logic        w_nearest;
`ifdef NRP_ROUND_MODES_EN
    always_comb begin
        w_nearest = (r_mode == 2'd0);
        case (r_mode)
            2'd0:    w_inc = 64'h200;
            2'd1:    w_inc = r_sign ? 64'h3FF : 64'h0;
            2'd2:    w_inc = r_sign ? 64'h0 : 64'h3FF;
            default: w_inc = 64'h0;
        endcase
    end
`else
    assign w_nearest = 1'b1;
    assign w_inc     = 64'h200;
`endif

    logic [13:0] w_neg;
    logic [63:0] w_mask;
    logic [63:0] w_sig_u;
    logic        w_tiny;
    logic [9:0]  w_rb;
    logic [63:0] w_sum;
    logic [63:0] w_frac;
    logic [13:0] w_exp_r;
    logic        w_ovf;

    // Rounding datapath; tininess is judged before rounding
    always_comb begin
        w_neg   = 14'd0 - r_exp;
        w_mask  = 64'd0;
        w_sig_u = r_sig;
        w_tiny  = 1'b0;
        if ($signed(r_exp) < 0) begin
            w_tiny = 1'b1;
            if (w_neg >= 14'd64) begin
                w_sig_u = {63'd0, |r_sig};
            end else begin
                w_mask  = (64'd1 << w_neg[5:0]) - 64'd1;
                w_sig_u = (r_sig >> w_neg[5:0]) | {63'd0, |(r_sig & w_mask)};
            end
        end
        w_rb   = w_sig_u[9:0];
        w_sum  = w_sig_u + w_inc;
        w_frac = w_sum >> 10;
        if (w_nearest && (w_rb == 10'h200)) w_frac[0] = 1'b0;
        w_exp_r = w_tiny ? 14'd0 : r_exp;
        if (w_frac == 64'd0) w_exp_r = 14'd0;
        // Non-negative exponent means w_sig_u == r_sig, so w_sum[63] is the carry
        w_ovf = !r_zero && (($signed(r_exp) > $signed(c_EXP_OVF)) ||
                            ((r_exp == c_EXP_OVF) && w_sum[63]));
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state  <= S_IDLE;
            r_sign   <= 1'b0;
            r_zexp   <= 14'd0;
            r_zsig   <= 64'd0;
            r_exp    <= 14'd0;
            r_sig    <= 64'd0;
            r_zero   <= 1'b0;
            r_nflags <= 3'd0;
            r_return <= 64'd0;
            r_flags  <= 3'd0;
            r_done   <= 1'b0;
`ifdef NRP_ROUND_MODES_EN
            r_mode   <= 2'd0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.ap_start) begin
                        r_sign  <= bus.zSign;
                        r_zexp  <= bus.zExp;
                        r_zsig  <= bus.zSig;
`ifdef NRP_ROUND_MODES_EN
                        r_mode  <= bus.round_mode;
`endif
                        r_state <= S_NORM;
                    end
                end
                S_NORM: begin
                    r_zero <= (r_zsig == 64'd0);
                    if (r_zsig[63]) begin
                        r_sig <= {1'b0, r_zsig[63:2], r_zsig[1] | r_zsig[0]};
                        r_exp <= r_zexp + 14'd1;
                    end else begin
                        r_sig <= r_zsig << w_sc;
                        r_exp <= r_zexp - {8'd0, w_sc};
                    end
                    r_state <= S_RND;
                end
                S_RND: begin
                    if (w_ovf) begin
                        r_nflags <= 3'b101;
`ifdef NRP_ROUND_MODES_EN
                        r_exp <= (w_inc != 64'd0) ? 14'h07FF : 14'h07FE;
                        r_sig <= (w_inc != 64'd0) ? 64'd0 : c_FRAC_MAX;
`else
                        r_exp <= 14'h07FF;
                        r_sig <= 64'd0;
`endif
                    end else begin
                        r_exp    <= w_exp_r;
                        r_sig    <= w_frac;
                        r_nflags <= {1'b0, w_tiny && (w_rb != 10'd0), w_rb != 10'd0};
                    end
                    r_state <= S_PACK;
                end
                default: begin
                    // Addition lets a carry out of the fraction bump the exponent
                    r_return <= {r_sign, 63'd0} + ({50'd0, r_exp} << 52) + r_sig;
                    r_flags  <= r_nflags;
                    r_done   <= 1'b1;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ap_done   = r_done;
    assign bus.ap_ready  = r_done;
    assign bus.ap_idle   = (r_state == S_IDLE);
    assign bus.ap_return = r_return;
    assign bus.flags     = r_flags;

endmodule

`default_nettype wire

// File: tb/tb_normalize_round_pack_float64.sv
// ============================================================================
// Module      : tb_normalize_round_pack_float64
// Description : Directed vector bench for normalize_round_pack_float64.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_normalize_round_pack_float64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    normalize_round_pack_float64_if bus ();

    normalize_round_pack_float64 dut (
        .ap_clk (clk),
        .ap_rst (rst),
        .bus    (bus)
    );

    typedef struct {
        logic        sign;
        logic [13:0] exp;
        logic [63:0] sig;
        logic [1:0]  mode;
        logic [63:0] ret;
        logic [2:0]  flg;
    } vec_t;

    vec_t vecs [19];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_job(input vec_t v, output logic [63:0] ret, output logic [2:0] flg,
                           output int lat, output logic idle_ok);
        int cyc;
        @(negedge clk);
        bus.zSign      = v.sign;
        bus.zExp       = v.exp;
        bus.zSig       = v.sig;
        bus.round_mode = v.mode;
        bus.ap_start   = 1'b1;
        @(posedge clk);
        #1;
        bus.ap_start   = 1'b0;
        // Scramble operands to show they were captured at start
        bus.zSign      = ~v.sign;
        bus.zExp       = ~v.exp;
        bus.zSig       = ~v.sig;
        bus.round_mode = ~v.mode;
        idle_ok = 1'b1;
        cyc = 0;
        lat = -1;
        while (cyc < 12) begin
            @(negedge clk);
            cyc++;
            if (bus.ap_done === 1'b1) begin
                lat = cyc - 1;
                break;
            end
            if (bus.ap_idle !== 1'b0) idle_ok = 1'b0;
        end
        ret = bus.ap_return;
        flg = bus.flags;
        if (lat < 0) begin
            total++;
            bad++;
            $display("FAIL timeout: got no ap_done expected ap_done within 12 cycles");
        end
    endtask

    initial begin
        logic [63:0] ret;
        logic [2:0]  flg;
        int          lat;
        logic        idle_ok;
        int          d1, d2, ndone;
        logic        seen_done;

        vecs[0]  = '{1'b0, 14'h03FE, 64'h4000_0000_0000_0000, 2'd0, 64'h3FF0_0000_0000_0000, 3'b000};
        vecs[1]  = '{1'b0, 14'h043C, 64'h0000_0000_0000_0001, 2'd0, 64'h3FF0_0000_0000_0000, 3'b000};
        vecs[2]  = '{1'b0, 14'h043C, 64'h0000_0000_0000_0000, 2'd0, 64'h0000_0000_0000_0000, 3'b000};
        vecs[3]  = '{1'b1, 14'h03FE, 64'h0000_0000_0000_0000, 2'd0, 64'h8000_0000_0000_0000, 3'b000};
        vecs[4]  = '{1'b0, 14'h03FE, 64'h4000_0000_0000_0200, 2'd0, 64'h3FF0_0000_0000_0000, 3'b001};
        vecs[5]  = '{1'b0, 14'h03FE, 64'h4000_0000_0000_0600, 2'd0, 64'h3FF0_0000_0000_0002, 3'b001};
        vecs[6]  = '{1'b0, 14'h03FE, 64'h7FFF_FFFF_FFFF_FE00, 2'd0, 64'h4000_0000_0000_0000, 3'b001};
        vecs[7]  = '{1'b0, 14'h03FE, 64'h8000_0000_0000_0000, 2'd0, 64'h4000_0000_0000_0000, 3'b000};
        vecs[8]  = '{1'b0, 14'h03FE, 64'h8000_0000_0000_0001, 2'd0, 64'h4000_0000_0000_0000, 3'b001};
        vecs[9]  = '{1'b0, 14'h07FE, 64'h4000_0000_0000_0000, 2'd0, 64'h7FF0_0000_0000_0000, 3'b101};
        vecs[10] = '{1'b0, 14'h07FD, 64'h7FFF_FFFF_FFFF_FFFF, 2'd0, 64'h7FF0_0000_0000_0000, 3'b101};
        vecs[11] = '{1'b0, 14'h07FD, 64'h4000_0000_0000_0000, 2'd0, 64'h7FE0_0000_0000_0000, 3'b000};
        vecs[12] = '{1'b0, 14'h3FFE, 64'h4000_0000_0000_0001, 2'd0, 64'h0004_0000_0000_0000, 3'b011};
        vecs[13] = '{1'b0, 14'h3F00, 64'h4000_0000_0000_0000, 2'd0, 64'h0000_0000_0000_0000, 3'b011};
        vecs[18] = '{1'b0, 14'h3FFF, 64'h4000_0000_0000_0000, 2'd0, 64'h0008_0000_0000_0000, 3'b000};
`ifdef NRP_ROUND_MODES_EN
        vecs[14] = '{1'b0, 14'h07FE, 64'h4000_0000_0000_0000, 2'd3, 64'h7FEF_FFFF_FFFF_FFFF, 3'b101};
        vecs[15] = '{1'b1, 14'h03FE, 64'h4000_0000_0000_0001, 2'd1, 64'hBFF0_0000_0000_0001, 3'b001};
        vecs[16] = '{1'b0, 14'h03FE, 64'h4000_0000_0000_0001, 2'd2, 64'h3FF0_0000_0000_0001, 3'b001};
        vecs[17] = '{1'b0, 14'h03FE, 64'h4000_0000_0000_03FF, 2'd1, 64'h3FF0_0000_0000_0000, 3'b001};
`else
        vecs[14] = '{1'b0, 14'h07FE, 64'h4000_0000_0000_0000, 2'd3, 64'h7FF0_0000_0000_0000, 3'b101};
        vecs[15] = '{1'b1, 14'h03FE, 64'h4000_0000_0000_0001, 2'd1, 64'hBFF0_0000_0000_0000, 3'b001};
        vecs[16] = '{1'b0, 14'h03FE, 64'h4000_0000_0000_0001, 2'd2, 64'h3FF0_0000_0000_0000, 3'b001};
        vecs[17] = '{1'b0, 14'h03FE, 64'h4000_0000_0000_03FF, 2'd1, 64'h3FF0_0000_0000_0001, 3'b001};
`endif

        bus.ap_start   = 1'b0;
        bus.zSign      = 1'b0;
        bus.zExp       = 14'd0;
        bus.zSig       = 64'd0;
        bus.round_mode = 2'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_idle",   {63'd0, bus.ap_idle},  64'd1);
        check("reset_done",   {63'd0, bus.ap_done},  64'd0);
        check("reset_ready",  {63'd0, bus.ap_ready}, 64'd0);
        check("reset_return", bus.ap_return,         64'd0);
        check("reset_flags",  {61'd0, bus.flags},    64'd0);

        for (int i = 0; i < 19; i++) begin
            run_job(vecs[i], ret, flg, lat, idle_ok);
            check($sformatf("vec%0d_return", i), ret, vecs[i].ret);
            check($sformatf("vec%0d_flags", i), {61'd0, flg}, {61'd0, vecs[i].flg});
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd3);
            if (i == 0) begin
                check("vec0_idle_low", {63'd0, idle_ok}, 64'd1);
                check("vec0_ready", {63'd0, bus.ap_ready}, 64'd1);
            end
        end

        // Reset while the job sits in the rounding state
        @(negedge clk);
        bus.zSign = 1'b0; bus.zExp = 14'h03FE; bus.zSig = 64'h4000_0000_0000_0600;
        bus.round_mode = 2'd0;
        bus.ap_start = 1'b1;
        @(posedge clk);
        #1 bus.ap_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_idle",   {63'd0, bus.ap_idle}, 64'd1);
        check("abort_return", bus.ap_return,        64'd0);
        check("abort_flags",  {61'd0, bus.flags},   64'd0);
        check("abort_done",   {63'd0, bus.ap_done}, 64'd0);
        rst = 1'b0;
        seen_done = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.ap_done === 1'b1) seen_done = 1'b1;
        end
        check("abort_no_done", {63'd0, seen_done}, 64'd0);
        run_job(vecs[12], ret, flg, lat, idle_ok);
        check("after_abort_return", ret, vecs[12].ret);
        check("after_abort_flags", {61'd0, flg}, {61'd0, vecs[12].flg});

        // ap_start held high across two jobs
        @(negedge clk);
        bus.zSign = 1'b0; bus.zExp = 14'h03FE; bus.zSig = 64'h4000_0000_0000_0600;
        bus.round_mode = 2'd0;
        bus.ap_start = 1'b1;
        d1 = -1; d2 = -1; ndone = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.ap_done === 1'b1) begin
                ndone++;
                if (ndone == 1) d1 = k;
                else begin
                    d2 = k;
                    bus.ap_start = 1'b0;
                    break;
                end
            end
        end
        bus.ap_start = 1'b0;
        check("b2b_done_count", 64'(ndone), 64'd2);
        check("b2b_spacing", 64'(d2 - d1), 64'd4);
        check("b2b_return", bus.ap_return, 64'h3FF0_0000_0000_0002);
        seen_done = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.ap_done === 1'b1) seen_done = 1'b1;
        end
        check("b2b_no_third", {63'd0, seen_done}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
